// File: rtl/mac_ctrl.sv
// Multiply-accumulate sequencer feeding a fixed-latency 4-bit multiplier; one operand pair in flight at a time.
// Sums each job's products into a saturating signed accumulator and presents the result on a valid/ready port.
module mac_ctrl #(
    parameter int ACC_W   = 12,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic             mul_start,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_sat
);

    localparam int CW = $clog2(MUL_LAT + 2);
    localparam logic [CW-1:0]    CNT_SAMPLE = CW'(MUL_LAT);
    localparam logic [CW-1:0]    CNT_DONE   = CW'(MUL_LAT + 1);
    localparam logic [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MWAIT = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_mul_a;
    logic [3:0]       r_mul_b;
    logic             r_last;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_count;
    logic             r_sat;

    logic             w_accept;
    logic             w_sample;
    logic             w_clear;
    logic [ACC_W:0]   w_sum;
    logic             w_pos_ovf;
    logic             w_neg_ovf;
    logic [ACC_W-1:0] w_acc_nxt;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_sample = (r_state == MWAIT) && (r_cnt == CNT_SAMPLE);
    assign w_clear  = (r_state == OUT) && out_ready;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-8){mul_p[7]}}, mul_p};
    assign w_pos_ovf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
    assign w_neg_ovf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
    assign w_acc_nxt = w_pos_ovf ? ACC_MAX :
                       w_neg_ovf ? ACC_MIN : w_sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = ISSUE;
            ISSUE:   w_next = MWAIT;
            MWAIT:   if (r_cnt == CNT_DONE) w_next = r_last ? OUT : IDLE;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_mul_a <= '0;
            r_mul_b <= '0;
            r_last  <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mul_a <= in_a;
                r_mul_b <= in_b;
                r_last  <= in_last;
            end

            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state == ISSUE) begin
                r_cnt <= CW'(1);
            end else if (r_state == MWAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_clear) begin
                r_acc   <= '0;
                r_count <= '0;
                r_sat   <= 1'b0;
            end else if (w_sample) begin
                r_acc <= w_acc_nxt;
                if (r_count != 8'hFF) begin
                    r_count <= r_count + 8'd1;
                end
                if (w_pos_ovf || w_neg_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    // Result fields read as zero outside OUT so a consumer never sees a partial sum.
    always_comb begin
        in_ready  = (r_state == IDLE);
        mul_start = (r_state == ISSUE);
        mul_a     = r_mul_a;
        mul_b     = r_mul_b;
        out_valid = 1'b0;
        out_sum   = '0;
        out_count = '0;
        out_sat   = 1'b0;
        if (r_state == OUT) begin
            out_valid = 1'b1;
            out_sum   = r_acc;
            out_count = r_count;
            out_sat   = r_sat;
        end
    end

endmodule
